// File: rtl/alu_isa_pkg.sv
// ============================================================================
// Module      : alu_isa_pkg
// Description : ALU instruction encodings, field positions, flag indices and
//               issue-controller state encodings shared across the ALU slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_isa_pkg;

    // Opcodes; 0000..1010 are plain arithmetic/logic ops that write Rd
    localparam logic [3:0] OP_ADD        = 4'b0000;
    localparam logic [3:0] OP_ARITH_LAST = 4'b1010;
    localparam logic [3:0] OP_CMP        = 4'b1011;
    localparam logic [3:0] OP_NOP        = 4'b1100;
    localparam logic [3:0] OP_LDR        = 4'b1101;
    localparam logic [3:0] OP_STR        = 4'b1110;
    localparam logic [3:0] OP_NOP_ALT    = 4'b1111;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int INSTR_OP_LSB   = 28;
    localparam int INSTR_COND_LSB = 24;
    localparam int INSTR_S_BIT    = 23;
    localparam int INSTR_RD_LSB   = 20;
    localparam int INSTR_RN_LSB   = 17;
    localparam int INSTR_RSVD_BIT = 16;
    localparam int INSTR_IV_LSB   = 0;
    localparam int INSTR_RM_LSB   = 0;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;
    localparam logic [1:0] ST_WB   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/cond_eval.sv
// ============================================================================
// Module      : cond_eval
// Description : Combinational condition-code check of Cond against NZCV.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_eval
    import alu_isa_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign w_n = flags[FLAG_N];
    assign w_z = flags[FLAG_Z];
    assign w_c = flags[FLAG_C];
    assign w_v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = w_z;
            COND_NE: pass = !w_z;
            COND_CS: pass = w_c;
            COND_CC: pass = !w_c;
            COND_MI: pass = w_n;
            COND_PL: pass = !w_n;
            COND_VS: pass = w_v;
            COND_VC: pass = !w_v;
            COND_HI: pass = w_c && !w_z;
            COND_LS: pass = !w_c || w_z;
            COND_GE: pass = (w_n == w_v);
            COND_LT: pass = (w_n != w_v);
            COND_GT: pass = !w_z && (w_n == w_v);
            COND_LE: pass = w_z || (w_n != w_v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Sequential issue/writeback controller for the MASTER_ALU:
//               decode, operand read, held execute, conditional writeback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_ctrl
    import alu_isa_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [2:0]  rf_raddr1,
    output logic [2:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    output logic [31:0] alu_reg1,
    output logic [31:0] alu_reg2,
    output logic [15:0] alu_iv,
    output logic [3:0]  alu_opcode,
    output logic [3:0]  alu_cond,
    output logic        alu_s,
    output logic [3:0]  alu_flag,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_new_flag,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [3:0]  flags,
    output logic        done,
    output logic        skipped,
    output logic        illegal
);

    localparam logic [3:0] c_exec_init = 4'(ALU_LAT - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_opcode;
    logic [3:0]  r_cond;
    logic        r_s;
    logic [2:0]  r_rd;
    logic [2:0]  r_rn;
    logic [15:0] r_iv;
    logic [31:0] r_reg1;
    logic [31:0] r_reg2;
    logic [3:0]  r_cnt;
    logic        r_rf_we;
    logic [2:0]  r_rf_waddr;
    logic [31:0] r_rf_wdata;
    logic [3:0]  r_new_flag;
    logic        r_flag_upd;
    logic [3:0]  r_flags;
    logic        r_done;
    logic        r_skipped;
    logic        r_illegal;

    logic        w_pass;
    logic        w_is_arith;
    logic        w_is_cmp;
    logic        w_is_illegal;
    logic        w_accept;
    logic        w_unused_rsvd;

    assign w_unused_rsvd = instr[INSTR_RSVD_BIT];
    assign w_accept      = instr_valid && (r_state == ST_IDLE);

    cond_eval u_cond_eval (
        .cond  (r_cond),
        .flags (r_flags),
        .pass  (w_pass)
    );

    always_comb begin
        w_is_arith   = 1'b0;
        w_is_cmp     = 1'b0;
        w_is_illegal = 1'b0;
        if (r_opcode <= OP_ARITH_LAST) begin
            w_is_arith = 1'b1;
        end else if (r_opcode == OP_CMP) begin
            w_is_cmp = 1'b1;
        end else if ((r_opcode == OP_LDR) || (r_opcode == OP_STR)) begin
            w_is_illegal = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (instr_valid) w_state_nxt = ST_READ;
            ST_READ: w_state_nxt = ST_EXEC;
            ST_EXEC: if (r_cnt == 4'd0) w_state_nxt = ST_WB;
            ST_WB:   w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Writeback outcome is decided on the last EXEC edge so every WB strobe is a flop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_opcode   <= 4'd0;
            r_cond     <= 4'd0;
            r_s        <= 1'b0;
            r_rd       <= 3'd0;
            r_rn       <= 3'd0;
            r_iv       <= 16'd0;
            r_reg1     <= 32'd0;
            r_reg2     <= 32'd0;
            r_cnt      <= 4'd0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= 3'd0;
            r_rf_wdata <= 32'd0;
            r_new_flag <= 4'd0;
            r_flag_upd <= 1'b0;
            r_flags    <= 4'd0;
            r_done     <= 1'b0;
            r_skipped  <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rf_we    <= 1'b0;
            r_done     <= 1'b0;
            r_skipped  <= 1'b0;
            r_illegal  <= 1'b0;
            r_flag_upd <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_opcode <= instr[INSTR_OP_LSB +: 4];
                        r_cond   <= instr[INSTR_COND_LSB +: 4];
                        r_s      <= instr[INSTR_S_BIT];
                        r_rd     <= instr[INSTR_RD_LSB +: 3];
                        r_rn     <= instr[INSTR_RN_LSB +: 3];
                        r_iv     <= instr[INSTR_IV_LSB +: 16];
                    end
                end
                ST_READ: begin
                    r_reg1 <= rf_rdata1;
                    r_reg2 <= rf_rdata2;
                    r_cnt  <= c_exec_init;
                end
                ST_EXEC: begin
                    if (r_cnt == 4'd0) begin
                        r_rf_wdata <= alu_result;
                        r_new_flag <= alu_new_flag;
                        r_rf_waddr <= r_rd;
                        r_done     <= 1'b1;
                        r_rf_we    <= w_is_arith && w_pass;
                        r_flag_upd <= w_pass && ((w_is_arith && r_s) || w_is_cmp);
                        r_skipped  <= !w_pass && (w_is_arith || w_is_cmp);
                        r_illegal  <= w_is_illegal;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_WB: begin
                    if (r_flag_upd) r_flags <= r_new_flag;
                end
                default: ;
            endcase
        end
    end

    // In IDLE the read address follows the incoming instruction so the
    // synchronous register file launches on the accept edge and returns
    // data during READ.
    assign rf_raddr1 = (r_state == ST_IDLE) ? instr[INSTR_RN_LSB +: 3] : r_rn;
    assign rf_raddr2 = (r_state == ST_IDLE) ? instr[INSTR_RM_LSB +: 3] : r_iv[INSTR_RM_LSB +: 3];

    assign instr_ready = (r_state == ST_IDLE);
    assign alu_reg1    = r_reg1;
    assign alu_reg2    = r_reg2;
    assign alu_iv      = r_iv;
    assign alu_opcode  = r_opcode;
    assign alu_cond    = r_cond;
    assign alu_s       = r_s;
    assign alu_flag    = r_flags;
    assign flags       = r_flags;
    assign rf_we       = r_rf_we;
    assign rf_waddr    = r_rf_waddr;
    assign rf_wdata    = r_rf_wdata;
    assign done        = r_done;
    assign skipped     = r_skipped;
    assign illegal     = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Directed self-checking bench for alu_issue_ctrl (ALU_LAT=3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_ctrl;

    localparam int LAT = 3;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [2:0]  rf_raddr1;
    logic [2:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic [31:0] alu_reg1;
    logic [31:0] alu_reg2;
    logic [15:0] alu_iv;
    logic [3:0]  alu_opcode;
    logic [3:0]  alu_cond;
    logic        alu_s;
    logic [3:0]  alu_flag;
    logic [31:0] alu_result;
    logic [3:0]  alu_new_flag;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [3:0]  flags;
    logic        done;
    logic        skipped;
    logic        illegal;

    logic [31:0] rf_mem [8];

    int          n_checks;
    int          n_fail;

    logic        wb_we;
    logic [2:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        wb_skip;
    logic        wb_ill;
    logic [3:0]  flags_after;

    alu_issue_ctrl #(.ALU_LAT(LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .rf_raddr1    (rf_raddr1),
        .rf_raddr2    (rf_raddr2),
        .rf_rdata1    (rf_rdata1),
        .rf_rdata2    (rf_rdata2),
        .alu_reg1     (alu_reg1),
        .alu_reg2     (alu_reg2),
        .alu_iv       (alu_iv),
        .alu_opcode   (alu_opcode),
        .alu_cond     (alu_cond),
        .alu_s        (alu_s),
        .alu_flag     (alu_flag),
        .alu_result   (alu_result),
        .alu_new_flag (alu_new_flag),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .flags        (flags),
        .done         (done),
        .skipped      (skipped),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous register file: one-cycle read latency, write on rf_we
    always @(posedge clk) begin
        rf_rdata1 <= rf_mem[rf_raddr1];
        rf_rdata2 <= rf_mem[rf_raddr2];
        if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction and capture the WB outcome plus post-WB flags
    task automatic run_instr(input logic [31:0] ins, input logic [31:0] res,
                             input logic [3:0] nf, input logic [31:0] e1,
                             input logic [31:0] e2);
        int  n;
        bit  seen;
        alu_result   = res;
        alu_new_flag = nf;
        n = 0;
        while (!instr_ready && n < 50) begin
            step();
            n++;
        end
        check("ready_before_issue", 32'(instr_ready), 32'd1);
        instr       = ins;
        instr_valid = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            step();
            n++;
            if (n == 1) begin
                instr_valid = 1'b0;
                check("read_raddr1", 32'(rf_raddr1), 32'(ins[19:17]));
                check("read_raddr2", 32'(rf_raddr2), 32'(ins[2:0]));
                check("read_ready_low", 32'(instr_ready), 32'd0);
            end
            if (n >= 2 && n <= 2 + LAT) begin
                check("hold_reg1", alu_reg1, e1);
                check("hold_reg2", alu_reg2, e2);
                check("hold_iv", 32'(alu_iv), 32'(ins[15:0]));
                check("hold_opcode", 32'(alu_opcode), 32'(ins[31:28]));
                check("hold_cond", 32'(alu_cond), 32'(ins[27:24]));
                check("hold_s", 32'(alu_s), 32'(ins[23]));
            end
            if (done) seen = 1'b1;
        end
        check("done_latency", 32'(n), 32'(2 + LAT));
        check("alu_flag_eq_flags", 32'(alu_flag), 32'(flags));
        wb_we    = rf_we;
        wb_waddr = rf_waddr;
        wb_wdata = rf_wdata;
        wb_skip  = skipped;
        wb_ill   = illegal;
        step();
        flags_after = flags;
        check("done_single_pulse", 32'(done), 32'd0);
        check("we_single_pulse", 32'(rf_we), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int acc[$];
        int dn[$];
        int n;
        int bad;
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        instr_valid  = 1'b0;
        instr        = 32'd0;
        alu_result   = 32'd0;
        alu_new_flag = 4'd0;
        for (int i = 0; i < 8; i++) rf_mem[i] = 32'd0;
        rf_mem[1] = 32'd5;
        rf_mem[2] = 32'd7;

        // Reset state
        step();
        step();
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_we", 32'(rf_we), 32'd0);
        check("rst_reg1", alu_reg1, 32'd0);
        check("rst_opcode", 32'(alu_opcode), 32'd0);
        rst_n = 1'b1;
        step();

        // ADD AL S=1 Rd=3 Rn=1 Rm=2
        run_instr(32'h0EB20002, 32'd12, 4'b0000, 32'd5, 32'd7);
        check("add_we", 32'(wb_we), 32'd1);
        check("add_waddr", 32'(wb_waddr), 32'd3);
        check("add_wdata", wb_wdata, 32'h0000000C);
        check("add_skip", 32'(wb_skip), 32'd0);
        check("add_ill", 32'(wb_ill), 32'd0);
        check("add_flags", 32'(flags_after), 32'd0);
        check("add_rf3", rf_mem[3], 32'd12);

        // CMP AL: flags only
        run_instr(32'hBE020002, 32'hDEADBEEF, 4'b0100, 32'd5, 32'd7);
        check("cmp_we", 32'(wb_we), 32'd0);
        check("cmp_skip", 32'(wb_skip), 32'd0);
        check("cmp_flags", 32'(flags_after), 32'd4);

        // ADD EQ with Z=1: writes and updates flags to 0110
        run_instr(32'h00B20002, 32'h55, 4'b0110, 32'd5, 32'd7);
        check("addeq_we", 32'(wb_we), 32'd1);
        check("addeq_wdata", wb_wdata, 32'h55);
        check("addeq_flags", 32'(flags_after), 32'd6);
        check("addeq_rf3", rf_mem[3], 32'h55);

        // ADD NE with Z=1: skipped
        run_instr(32'h01B20002, 32'h99, 4'b0000, 32'd5, 32'd7);
        check("addne_skip", 32'(wb_skip), 32'd1);
        check("addne_we", 32'(wb_we), 32'd0);
        check("addne_flags", 32'(flags_after), 32'd6);
        check("addne_rf3", rf_mem[3], 32'h55);

        // LDR AL and LDR NV: illegal regardless of condition
        run_instr(32'hDE020002, 32'h11, 4'b1111, 32'd5, 32'd7);
        check("ldr_ill", 32'(wb_ill), 32'd1);
        check("ldr_we", 32'(wb_we), 32'd0);
        check("ldr_skip", 32'(wb_skip), 32'd0);
        check("ldr_flags", 32'(flags_after), 32'd6);
        run_instr(32'hDF020002, 32'h11, 4'b1111, 32'd5, 32'd7);
        check("ldrnv_ill", 32'(wb_ill), 32'd1);
        check("ldrnv_skip", 32'(wb_skip), 32'd0);

        // HI with C=1,Z=1 fails; LS passes and sets flags 1001
        run_instr(32'h08B20002, 32'h66, 4'b0000, 32'd5, 32'd7);
        check("hi_skip", 32'(wb_skip), 32'd1);
        check("hi_flags", 32'(flags_after), 32'd6);
        run_instr(32'h09B20002, 32'h77, 4'b1001, 32'd5, 32'd7);
        check("ls_we", 32'(wb_we), 32'd1);
        check("ls_flags", 32'(flags_after), 32'd9);

        // GE with N=V=1 passes, S=0 keeps flags; LT fails
        run_instr(32'h0A320002, 32'h21, 4'b1111, 32'd5, 32'd7);
        check("ge_we", 32'(wb_we), 32'd1);
        check("ge_wdata", wb_wdata, 32'h21);
        check("ge_flags", 32'(flags_after), 32'd9);
        run_instr(32'h0BB20002, 32'h31, 4'b0000, 32'd5, 32'd7);
        check("lt_skip", 32'(wb_skip), 32'd1);
        check("lt_we", 32'(wb_we), 32'd0);

        // NOP: done only
        run_instr(32'hCE000000, 32'h41, 4'b0000, 32'd0, 32'd0);
        check("nop_we", 32'(wb_we), 32'd0);
        check("nop_skip", 32'(wb_skip), 32'd0);
        check("nop_ill", 32'(wb_ill), 32'd0);
        check("nop_flags", 32'(flags_after), 32'd9);

        // Throughput with instr_valid held high
        instr       = 32'h0E320002;
        alu_result  = 32'h12;
        instr_valid = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (instr_ready) acc.push_back(c);
            if (done) dn.push_back(c);
            step();
        end
        instr_valid = 1'b0;
        check("tp_accepts", 32'(acc.size()), 32'd3);
        check("tp_dones", 32'(dn.size()), 32'd2);
        if (acc.size() >= 2) check("tp_interval", 32'(acc[1] - acc[0]), 32'd6);
        else check("tp_interval", 32'(acc.size()), 32'd2);
        if (dn.size() >= 1 && acc.size() >= 1) check("tp_done_lat", 32'(dn[0] - acc[0]), 32'd5);
        else check("tp_done_lat", 32'(dn.size()), 32'd1);
        n = 0;
        while (!done && n < 20) begin
            step();
            n++;
        end
        check("tp_drain_done", 32'(done), 32'd1);
        step();

        // Reset during EXEC
        check("pre_rst_flags", 32'(flags), 32'd9);
        instr        = 32'h0EB20002;
        alu_new_flag = 4'b0110;
        instr_valid  = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        instr = 32'd0;
        check("midrst_ready", 32'(instr_ready), 32'd1);
        check("midrst_flags", 32'(flags), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_we", 32'(rf_we), 32'd0);
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (done || rf_we) bad++;
        end
        check("midrst_no_wb", 32'(bad), 32'd0);
        check("midrst_flags_hold", 32'(flags), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequential instruction issue/writeback controller that drives the MASTER_ALU datapath.
- Accepts one 32-bit ALU instruction per handshake and decodes it into OpCode/Cond/S/IV plus register selects.
- Reads operands from a synchronous register file, holds ALU inputs stable for ALU_LAT cycles, evaluates Cond against the architectural NZCV register, then conditionally writes back Result and New_Flag.
- Owns the flag register the ALU reads as Flag.

Parameters:
- ALU_LAT, 1: cycles ALU inputs are held before Result/New_Flag are sampled; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- instr_valid  in  1  instruction offered
- instr_ready  out  1  controller can accept
- instr  in  32  fields: [31:28] OpCode, [27:24] Cond, [23] S, [22:20] Rd, [19:17] Rn, [16] reserved, [15:0] IV; Rm = IV[2:0]
- rf_raddr1  out  3  Rn select
- rf_raddr2  out  3  Rm select
- rf_rdata1  in  32  Rn data, valid one cycle after address
- rf_rdata2  in  32  Rm data, valid one cycle after address
- alu_reg1  out  32  to ALU Reg1
- alu_reg2  out  32  to ALU Reg2
- alu_iv  out  16  to ALU IV
- alu_opcode  out  4  to ALU OpCode
- alu_cond  out  4  to ALU Cond
- alu_s  out  1  to ALU S
- alu_flag  out  4  to ALU Flag (equals flags)
- alu_result  in  32  ALU Result
- alu_new_flag  in  4  ALU New_Flag
- rf_we  out  1  register write strobe
- rf_waddr  out  3  Rd
- rf_wdata  out  32  write data
- flags  out  4  architectural {N,Z,C,V}
- done  out  1  one-cycle completion pulse
- skipped  out  1  with done: condition failed
- illegal  out  1  with done: opcode not handled here

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE. All outputs 0 except instr_ready=1. Flags=0000. Any in-flight instruction is dropped with no done, no write, and no flag change.
- States: IDLE -> READ -> EXEC -> WB -> IDLE.
- IDLE:
  - instr_ready=1.
  - instr_valid&&instr_ready latches instr and moves to READ. Otherwise stays in IDLE.
- READ (1 cycle):
  - rf_raddr1/2 are driven from the latched Rn/Rm.
  - At exit, rf_rdata1/2 are captured into alu_reg1/2.
  - EXEC cycle counter is loaded with ALU_LAT-1.
- EXEC (ALU_LAT cycles):
  - alu_reg1/2, alu_iv, alu_opcode, alu_cond and alu_s are held constant.
  - On the final EXEC cycle, alu_result and alu_new_flag are registered.
- WB (1 cycle):
  - Condition check against flags:
    - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
    - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
    - 1110 AL 1; 1111 NV 0
  - Condition passes and OpCode is 0000–1010: rf_we=1, rf_waddr=Rd, rf_wdata=registered result.
  - OpCode 1011 (CMP): no write.
  - Condition passes and (S=1 or OpCode=1011): flags <= registered new_flag. Otherwise flags are unchanged.
  - OpCode 1100 or 1111: NOP. No write, no flag update, done only.
  - OpCode 1101/1110 (LDR/STR, owned by memory control): illegal=1. No write, no flag update. Condition is not evaluated.
  - Condition fails on a legal opcode: skipped=1, no side effects.
  - done=1 every WB.
- Latency: accept at cycle 0, done/rf_we at cycle 2+ALU_LAT. instr_ready is low from READ through WB. Maximum throughput is one instruction per 3+ALU_LAT cycles.
- Back-to-back instructions see flags already updated by the previous WB; no forwarding is needed.
- rf_we, done, skipped and illegal are registered and high only in WB.
- The reserved bit 16 is ignored.

Decomposition:
- Shared include/package alu_isa_pkg holds:
  - OpCode constants (OP_ADD=0000 … OP_CMP=1011, OP_LDR=1101, OP_STR=1110)
  - Cond constants
  - instruction field bit positions
  - flag bit indices N=3, Z=2, C=1, V=0
  - FSM state encodings
- One combinational sub-module, cond_eval (inputs cond[3:0], flags[3:0]; output pass), reusable by branch logic.

Test Plan:
- ADD: RF model R1=5, R2=7; instr=0x0EB20002 (ADD AL S=1 Rd=3 Rn=1 Rm=2); ALU model returns 12, flags 0000 → cycle 3: rf_we=1, rf_waddr=3, rf_wdata=0x0000000C, flags=0000, done=1.
- CMP: instr=0xBE020002 with ALU new_flag=0100 → rf_we stays 0, flags=0100 after WB, done=1, skipped=0.
- Condition pass/skip: with flags Z=1, ADD EQ (0x00B20002) writes R3. Then ADD NE (0x01B20002) → skipped=1, rf_we=0, flags unchanged.
- LDR: instr=0xDE020002 → illegal=1 with done, no write, flags unchanged.
- Throughput: ALU_LAT=3, instr_valid held high → accepts every 6 cycles. ALU inputs are stable for exactly 3 EXEC cycles; done arrives 5 cycles after accept.
- Reset mid-EXEC: rst_n=0 for one cycle → IDLE, instr_ready=1, flags=0000, no done or rf_we for the aborted instruction.
